axi_line_writer: RTL
====================

# axi_line_writer

AXI4 write-channel master that writes one 64-byte cache line to memory as an 8-beat burst on the AW/W/B channels. It is the write-direction counterpart of the core's instruction-fetch read path. It sits between the core's store/writeback logic and the `m_axi_aw*`/`m_axi_w*`/`m_axi_b*` ports of `top`. It accepts one line request at a time, issues the address and data phases concurrently, waits for the write response, and reports completion with an error flag.

## Interface
Parameters:
- `ID_WIDTH`, 13, AXI ID width
- `ADDR_WIDTH`, 64, AXI address width
- `DATA_WIDTH`, 64, AXI data width; fixed at 64 for this block
- `STRB_WIDTH`, `DATA_WIDTH/8`, write strobe width
- `AWID`, 0, constant ID driven on `m_axi_awid`

Ports:
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-low reset (asserted when 0)
- `req_valid`  in  1  line write request
- `req_ready`  out  1  block idle, can accept a request
- `req_addr`  in  64  line address; bits [5:0] ignored
- `req_data`  in  512  line data; beat i = bits [64i+63:64i]
- `req_strb`  in  64  byte strobes; beat i = bits [8i+7:8i]
- `done`  out  1  one-cycle pulse when the write response is received
- `done_err`  out  1  valid with `done`; 1 if `m_axi_bresp[1]` was set (SLVERR/DECERR)
- `m_axi_awid`, `m_axi_awaddr`, `m_axi_awlen`, `m_axi_awsize`, `m_axi_awburst`, `m_axi_awlock`, `m_axi_awcache`, `m_axi_awprot`, `m_axi_awvalid`  out  per AXI4 widths  write address channel
- `m_axi_awready`  in  1
- `m_axi_wdata`  out  64, `m_axi_wstrb`  out  8, `m_axi_wlast`  out  1, `m_axi_wvalid`  out  1  write data channel
- `m_axi_wready`  in  1
- `m_axi_bid`  in  `ID_WIDTH`, `m_axi_bresp`  in  2, `m_axi_bvalid`  in  1  write response channel
- `m_axi_bready`  out  1

## Operation
- All outputs are registered.
- Constant fields:
  - `awid` = `AWID`
  - `awlen` = 7 (8 beats)
  - `awsize` = 3 (8 bytes)
  - `awburst` = 1 (INCR)
  - `awlock` = 0
  - `awcache` = 0
  - `awprot` = 3'h6
- `awaddr` = {`req_addr`[63:6], 6'b0}, latched at acceptance.
- States:
  - IDLE: `req_ready`=1. On `req_valid && req_ready`, latch addr/data/strb, set `awvalid`=1, `wvalid`=1 with beat 0, beat counter=0, `aw_done`=0, then go to BURST.
  - BURST:
    - AW handshake (`awvalid && awready`): drop `awvalid`, set `aw_done`.
    - W handshake (`wvalid && wready`): advance the beat counter and present the next beat's data/strb on the following cycle.
    - `wlast`=1 exactly when the presented beat is 7.
    - After the beat-7 handshake, drop `wvalid`.
    - When both AW is done and beat 7 has been accepted (either order, including the same cycle), set `bready`=1 and go to RESP.
  - RESP: on `bvalid && bready`, drop `bready`, pulse `done`=1 for one cycle, set `done_err`=`bresp[1]`, set `req_ready`=1, return to IDLE.
- `bid` is not checked.
- `wvalid` never deasserts before its handshake, and `wdata`/`wstrb` stay stable while `wvalid && !wready`. The same holds for `awvalid` and `awaddr`.
- W beats may complete before AW is accepted. The block never waits for `awready` before driving W.
- A `bvalid` seen outside RESP is ignored; `bready` is 0 there.
- `req_valid` is ignored outside IDLE.

## Timing
- Reset (`reset`==0 at posedge) forces:
  - state=IDLE, `req_ready`=1
  - `awvalid`=0, `wvalid`=0, `wlast`=0, `bready`=0
  - `done`=0, `done_err`=0
  - beat counter=0, `awaddr`=0, `wdata`=0, `wstrb`=0
- Reset mid-burst abandons the transaction with no `done`. Valids are low on the first cycle after reset.
- A request accepted at edge N gives `awvalid`=`wvalid`=1 from cycle N+1.
- Minimum latency with `awready`=`wready`=1 and `bvalid` returned the cycle `bready` rises:
  - W beats on cycles N+1..N+8
  - `bready` high on N+9
  - `done` on N+10, together with `req_ready`=1
- Back-to-back requests: the next request can be accepted in the same cycle `done` is high.
- Throughput is 1 beat/cycle when `wready` is held high.

## Test plan
- Request addr 0x8000_1234, data beat i = 0x1111_1111_1111_1111*i, strb all 1s, slave always ready, B OKAY:
  - `awaddr`=0x8000_1200, `awlen`=7, `awburst`=1
  - 8 beats with correct data, `wlast` only on beat 7
  - `done`=1 with `done_err`=0 ten cycles after acceptance
- `wready` toggles 1,0,1,0…:
  - `wdata`/`wstrb` stay stable during each stall
  - exactly 8 handshakes, `wlast` on the 8th
- `awready` held 0 until all 8 W beats are accepted, then pulsed once:
  - `bready` rises the cycle after the AW handshake, not before
- `req_strb`=0x00FF_0000_0000_00F0:
  - beat 0 `wstrb`=0xF0
  - beat 6 `wstrb`=0xFF
  - all other beats `wstrb`=0x00
- B response `bresp`=2'b10 → `done`=1 with `done_err`=1. The next request is accepted in that same cycle and completes with `done_err`=0 when `bresp`=OKAY.
- `reset`=0 asserted on beat 3 of a burst:
  - next cycle `awvalid`=`wvalid`=`bready`=0, `req_ready`=1, no `done`
  - a new request after reset starts at beat 0

Source files
------------

// File: rtl/axi_line_writer_if.sv
// axi_line_writer_if: AXI4 write address, write data and write response channels
interface axi_line_writer_if #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ID_WIDTH-1:0]   m_axi_awid;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic [2:0]            m_axi_awsize;
    logic [1:0]            m_axi_awburst;
    logic                  m_axi_awlock;
    logic [3:0]            m_axi_awcache;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_WIDTH-1:0] m_axi_wstrb;
    logic                  m_axi_wlast;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [ID_WIDTH-1:0]   m_axi_bid;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
    );
endinterface

// File: rtl/axi_line_writer.sv
// axi_line_writer: writes one 64-byte line as an 8-beat AXI4 INCR burst and reports the response
module axi_line_writer #(
    parameter int                  ID_WIDTH   = 13,
    parameter int                  ADDR_WIDTH = 64,
    parameter int                  DATA_WIDTH = 64,
    parameter int                  STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [ID_WIDTH-1:0] AWID       = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [63:0]             req_addr,
    input  logic [8*DATA_WIDTH-1:0] req_data,
    input  logic [8*STRB_WIDTH-1:0] req_strb,
    output logic                    done,
    output logic                    done_err,
    axi_line_writer_if.master       m_axi
);
    typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic                    bready_q, bready_d, done_q, done_d, done_err_q, done_err_d;
    logic                    req_ready_q, req_ready_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [2:0]              beat_q, beat_d, beat_nx;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [8*DATA_WIDTH-1:0] line_q, line_d;
    logic [8*STRB_WIDTH-1:0] lstrb_q, lstrb_d;
    logic                    aw_hs, w_hs, b_hs, aw_fin, w_fin;
    logic                    unused_ok;

    assign aw_hs   = awvalid_q && m_axi.m_axi_awready;
    assign w_hs    = wvalid_q && m_axi.m_axi_wready;
    assign b_hs    = bready_q && m_axi.m_axi_bvalid;
    assign aw_fin  = aw_done_q || aw_hs;
    assign w_fin   = w_done_q || (w_hs && wlast_q);
    assign beat_nx = beat_q + 3'd1;

    assign m_axi.m_axi_awid    = AWID;
    assign m_axi.m_axi_awaddr  = awaddr_q;
    assign m_axi.m_axi_awlen   = 8'd7;
    assign m_axi.m_axi_awsize  = 3'd3;
    assign m_axi.m_axi_awburst = 2'd1;
    assign m_axi.m_axi_awlock  = 1'b0;
    assign m_axi.m_axi_awcache = 4'd0;
    assign m_axi.m_axi_awprot  = 3'h6;
    assign m_axi.m_axi_awvalid = awvalid_q;
    assign m_axi.m_axi_wdata   = wdata_q;
    assign m_axi.m_axi_wstrb   = wstrb_q;
    assign m_axi.m_axi_wlast   = wlast_q;
    assign m_axi.m_axi_wvalid  = wvalid_q;
    assign m_axi.m_axi_bready  = bready_q;
    assign req_ready           = req_ready_q;
    assign done                = done_q;
    assign done_err            = done_err_q;

    // The response ID, the low response bit and the line offset bits carry no information here
    assign unused_ok = ^{m_axi.m_axi_bid, m_axi.m_axi_bresp[0], req_addr[5:0]};

    // Next state: AW and W run independently in BURST; the response phase starts once both finish
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        bready_d    = bready_q;
        done_d      = 1'b0;
        done_err_d  = 1'b0;
        req_ready_d = req_ready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        beat_d      = beat_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        line_d      = line_q;
        lstrb_d     = lstrb_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d     = BURST;
                    req_ready_d = 1'b0;
                    awaddr_d    = ADDR_WIDTH'({req_addr[63:6], 6'b0});
                    line_d      = req_data;
                    lstrb_d     = req_strb;
                    wdata_d     = req_data[DATA_WIDTH-1:0];
                    wstrb_d     = req_strb[STRB_WIDTH-1:0];
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    wlast_d     = 1'b0;
                    beat_d      = 3'd0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                end
            end
            BURST: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs && wlast_q) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                    w_done_d = 1'b1;
                end else if (w_hs) begin
                    beat_d  = beat_nx;
                    wdata_d = line_q[int'(beat_nx) * DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d = lstrb_q[int'(beat_nx) * STRB_WIDTH +: STRB_WIDTH];
                    wlast_d = (beat_nx == 3'd7);
                end
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    done_d      = 1'b1;
                    done_err_d  = m_axi.m_axi_bresp[1];
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
            req_ready_q <= 1'b1;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            beat_q      <= 3'd0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            line_q      <= '0;
            lstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            done_err_q  <= done_err_d;
            req_ready_q <= req_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            beat_q      <= beat_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            line_q      <= line_d;
            lstrb_q     <= lstrb_d;
        end
    end
endmodule
